// File: rtl/cic3_row_readout_ctrl.sv
// -----------------------------------------------------------------------------
// cic3_row_readout_ctrl
//
// Readout sequencer for one row of CIC3 decimation filters. On every accepted
// decimated-sample strobe all filter outputs are snapshotted into shadow
// registers together with the channel mask. The enabled channels are then
// streamed out lowest index first, one word per handshake, tagged with their
// channel index. A strobe that arrives while a frame is still being scanned
// is dropped and flagged in the sticky overrun bit. The one exception is a
// strobe in the same cycle as the final handshake, which starts the next
// frame with no gap.
//
// Ports:
//   clk            common high-speed modulator clock
//   reset_n        asynchronous active-low reset
//   filt_out       concatenated filter outputs, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   sample_strobe  one-cycle pulse, filter outputs valid this cycle
//   enable         global readout enable
//   chan_mask      per-channel readout enable, bit k = channel k
//   out_data       snapshot word being presented
//   out_chan       channel index of out_data
//   out_valid      word valid
//   out_ready      downstream accepts word
//   out_last       final word of the current frame
//   busy           frame scan in progress
//   overrun        sticky: strobe dropped because the scan was incomplete
//   overrun_clr    clears overrun (a coincident new overrun wins)
//   frame_count    completed frames, wraps
//   dbg_state      current FSM state (0 = IDLE, 1 = SCAN)
//
// Output stream handshake: a word transfers on every cycle where out_valid
// and out_ready are both high. Once out_valid is raised, it and
// out_data/out_chan/out_last hold steady until that transfer happens. Only
// reset drops out_valid without a transfer. out_valid does not depend
// combinationally on out_ready.
// -----------------------------------------------------------------------------
module cic3_row_readout_ctrl #(
  parameter int NUM_FILTERS = 24,
  parameter int DATA_WIDTH  = 25,
  parameter int CH_W        = 5,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_FILTERS*DATA_WIDTH-1:0] filt_out,
  input  logic                              sample_strobe,
  input  logic                              enable,
  input  logic [NUM_FILTERS-1:0]            chan_mask,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [CH_W-1:0]                   out_chan,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              overrun,
  input  logic                              overrun_clr,
  output logic [FRAME_CNT_W-1:0]            frame_count,
  output logic                              dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]  shadow_q   [NUM_FILTERS];
  logic [DATA_WIDTH-1:0]  filt_words [NUM_FILTERS];
  logic [NUM_FILTERS-1:0] pending_q, pending_d;

  logic [DATA_WIDTH-1:0]  out_data_d;
  logic [CH_W-1:0]        out_chan_d;
  logic                   out_valid_d;
  logic                   out_last_d;
  logic                   busy_d;
  logic                   overrun_d;
  logic [FRAME_CNT_W-1:0] frame_count_d;

  logic                   handshake;
  logic                   last_beat;
  logic                   strobe_ok;
  logic                   accept;
  logic                   drop;
  logic [NUM_FILTERS-1:0] retire_vec;
  logic [NUM_FILTERS-1:0] pres_vec;
  logic [CH_W-1:0]        pres_idx;
  logic                   pres_single;
  logic [DATA_WIDTH-1:0]  pres_word;

  // Lowest set bit wins, so the scan walks channels in ascending order.
  function automatic logic [CH_W-1:0] lowest_idx(input logic [NUM_FILTERS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = CH_W'(i);
    end
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_FILTERS; k++) begin
      filt_words[k] = filt_out[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign handshake = out_valid & out_ready;
  assign last_beat = handshake & out_last;
  // A disabled or empty-mask strobe is not a frame request at all.
  assign strobe_ok = sample_strobe & enable & (|chan_mask);
  // The final-beat handshake frees the shadow this cycle, so a strobe that
  // coincides with it can be taken without disturbing the frame.
  assign accept    = strobe_ok & ((state_q == IDLE) | last_beat);
  assign drop      = strobe_ok & (state_q == SCAN) & ~last_beat;

  assign retire_vec = handshake ? (pending_q & ~(NUM_FILTERS'(1) << out_chan)) : pending_q;

  // The next word comes from the incoming snapshot on a new frame. It is
  // read straight from filt_out because the shadow only loads at this edge.
  assign pres_vec    = accept ? chan_mask : retire_vec;
  assign pres_idx    = lowest_idx(pres_vec);
  assign pres_single = (pres_vec != '0) && ((pres_vec & (pres_vec - NUM_FILTERS'(1))) == '0);
  assign pres_word   = accept ? filt_words[pres_idx] : shadow_q[pres_idx];

  assign dbg_state = (state_q == SCAN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    out_data_d    = out_data;
    out_chan_d    = out_chan;
    out_valid_d   = out_valid;
    out_last_d    = out_last;
    busy_d        = busy;
    overrun_d     = overrun;
    frame_count_d = frame_count;

    if (last_beat) frame_count_d = frame_count + FRAME_CNT_W'(1);

    if (overrun_clr) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = SCAN;
          pending_d   = chan_mask;
          out_valid_d = 1'b1;
          out_chan_d  = pres_idx;
          out_data_d  = pres_word;
          out_last_d  = pres_single;
          busy_d      = 1'b1;
        end
      end
      SCAN: begin
        if (accept) begin
          pending_d   = chan_mask;
          out_valid_d = 1'b1;
          out_chan_d  = pres_idx;
          out_data_d  = pres_word;
          out_last_d  = pres_single;
          busy_d      = 1'b1;
        end else if (handshake) begin
          pending_d = retire_vec;
          if (retire_vec == '0) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_chan_d  = '0;
            out_data_d  = '0;
            busy_d      = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            out_chan_d  = pres_idx;
            out_data_d  = pres_word;
            out_last_d  = pres_single;
            busy_d      = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= '0;
      out_data    <= '0;
      out_chan    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
      for (int k = 0; k < NUM_FILTERS; k++) shadow_q[k] <= '0;
    end else begin
      pending_q   <= pending_d;
      out_data    <= out_data_d;
      out_chan    <= out_chan_d;
      out_valid   <= out_valid_d;
      out_last    <= out_last_d;
      busy        <= busy_d;
      overrun     <= overrun_d;
      frame_count <= frame_count_d;
      if (accept) begin
        for (int k = 0; k < NUM_FILTERS; k++) shadow_q[k] <= filt_words[k];
      end
    end
  end

endmodule

// File: tb/tb_cic3_row_readout_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cic3_row_readout_ctrl
//
// Directed bench for the row readout sequencer. Each scenario task drives
// its stimulus and checks outputs inline one time unit after the rising edge.
// Expected values are hand-derived from the channel pattern loaded
// (channel k = base + k).
// -----------------------------------------------------------------------------
module tb_cic3_row_readout_ctrl;

  localparam int NF  = 24;
  localparam int DW  = 25;
  localparam int CW  = 5;
  localparam int FCW = 16;

  logic              clk;
  logic              reset_n;
  logic [NF*DW-1:0]  filt_out;
  logic              sample_strobe;
  logic              enable;
  logic [NF-1:0]     chan_mask;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_chan;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              overrun;
  logic              overrun_clr;
  logic [FCW-1:0]    frame_count;
  logic              dbg_state;

  int tests_run;
  int tests_failed;

  cic3_row_readout_ctrl #(
    .NUM_FILTERS (NF),
    .DATA_WIDTH  (DW),
    .CH_W        (CW),
    .FRAME_CNT_W (FCW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .filt_out      (filt_out),
    .sample_strobe (sample_strobe),
    .enable        (enable),
    .chan_mask     (chan_mask),
    .out_data      (out_data),
    .out_chan      (out_chan),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
    .frame_count   (frame_count),
    .dbg_state     (dbg_state)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- drivers
  task automatic set_data(input int base);
    for (int k = 0; k < NF; k++) filt_out[k*DW +: DW] = DW'(base + k);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    reset_n = 1'b0; filt_out = '0; sample_strobe = 1'b0; enable = 1'b0;
    chan_mask = '0; out_ready = 1'b0; overrun_clr = 1'b0;
    step(); step();
    tests_run++; if (out_valid !== 1'b0)  begin tests_failed++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests_run++; if (busy !== 1'b0)       begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (out_data !== '0)     begin tests_failed++; $display("FAIL reset_data: got %0d want 0", out_data); end
    tests_run++; if (out_chan !== '0)     begin tests_failed++; $display("FAIL reset_chan: got %0d want 0", out_chan); end
    tests_run++; if (out_last !== 1'b0)   begin tests_failed++; $display("FAIL reset_last: got %b want 0", out_last); end
    tests_run++; if (overrun !== 1'b0)    begin tests_failed++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tests_run++; if (frame_count !== '0)  begin tests_failed++; $display("FAIL reset_fcount: got %0d want 0", frame_count); end
    tests_run++; if (dbg_state !== 1'b0)  begin tests_failed++; $display("FAIL reset_state: got %b want 0", dbg_state); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_full_frame();
    enable = 1'b1; chan_mask = 24'hFFFFFF; out_ready = 1'b1;
    set_data(100);
    strobe();
    for (int k = 0; k < NF; k++) begin
      tests_run++; if (out_valid !== 1'b1)       begin tests_failed++; $display("FAIL full_valid[%0d]: got %b want 1", k, out_valid); end
      tests_run++; if (out_chan !== CW'(k))      begin tests_failed++; $display("FAIL full_chan[%0d]: got %0d want %0d", k, out_chan, k); end
      tests_run++; if (out_data !== DW'(100 + k)) begin tests_failed++; $display("FAIL full_data[%0d]: got %0d want %0d", k, out_data, 100 + k); end
      tests_run++; if (out_last !== (k == NF - 1)) begin tests_failed++; $display("FAIL full_last[%0d]: got %b want %b", k, out_last, (k == NF - 1)); end
      tests_run++; if (busy !== 1'b1)            begin tests_failed++; $display("FAIL full_busy[%0d]: got %b want 1", k, busy); end
      step();
    end
    tests_run++; if (out_valid !== 1'b0)   begin tests_failed++; $display("FAIL full_end_valid: got %b want 0", out_valid); end
    tests_run++; if (busy !== 1'b0)        begin tests_failed++; $display("FAIL full_end_busy: got %b want 0", busy); end
    tests_run++; if (frame_count !== 16'd1) begin tests_failed++; $display("FAIL full_fcount: got %0d want 1", frame_count); end
    tests_run++; if (dbg_state !== 1'b0)   begin tests_failed++; $display("FAIL full_end_state: got %b want 0", dbg_state); end
  endtask

  task automatic test_sparse_mask();
    int exp_ch [3];
    exp_ch = '{0, 2, 23};
    chan_mask = 24'h800005;
    set_data(200);
    strobe();
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (out_valid !== 1'b1)               begin tests_failed++; $display("FAIL sparse_valid[%0d]: got %b want 1", i, out_valid); end
      tests_run++; if (out_chan !== CW'(exp_ch[i]))      begin tests_failed++; $display("FAIL sparse_chan[%0d]: got %0d want %0d", i, out_chan, exp_ch[i]); end
      tests_run++; if (out_data !== DW'(200 + exp_ch[i])) begin tests_failed++; $display("FAIL sparse_data[%0d]: got %0d want %0d", i, out_data, 200 + exp_ch[i]); end
      tests_run++; if (out_last !== (i == 2))            begin tests_failed++; $display("FAIL sparse_last[%0d]: got %b want %b", i, out_last, (i == 2)); end
      step();
    end
    tests_run++; if (out_valid !== 1'b0)    begin tests_failed++; $display("FAIL sparse_end_valid: got %b want 0", out_valid); end
    tests_run++; if (frame_count !== 16'd2) begin tests_failed++; $display("FAIL sparse_fcount: got %0d want 2", frame_count); end
    // A strobe with an empty mask is ignored entirely.
    chan_mask = '0;
    strobe();
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL zeromask_valid[%0d]: got %b want 0", i, out_valid); end
      tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("FAIL zeromask_busy[%0d]: got %b want 0", i, busy); end
      step();
    end
    tests_run++; if (frame_count !== 16'd2) begin tests_failed++; $display("FAIL zeromask_fcount: got %0d want 2", frame_count); end
    tests_run++; if (overrun !== 1'b0)      begin tests_failed++; $display("FAIL zeromask_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_stall();
    chan_mask = 24'h000003; out_ready = 1'b0;
    set_data(300);
    strobe();
    tests_run++; if (out_valid !== 1'b1)  begin tests_failed++; $display("FAIL stall_first_valid: got %b want 1", out_valid); end
    tests_run++; if (out_data !== DW'(300)) begin tests_failed++; $display("FAIL stall_first_data: got %0d want 300", out_data); end
    set_data(999);
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++; if (out_valid !== 1'b1)    begin tests_failed++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
      tests_run++; if (out_chan !== CW'(0))   begin tests_failed++; $display("FAIL stall_chan[%0d]: got %0d want 0", i, out_chan); end
      tests_run++; if (out_data !== DW'(300)) begin tests_failed++; $display("FAIL stall_data[%0d]: got %0d want 300", i, out_data); end
      tests_run++; if (out_last !== 1'b0)     begin tests_failed++; $display("FAIL stall_last[%0d]: got %b want 0", i, out_last); end
    end
    out_ready = 1'b1;
    step();
    tests_run++; if (out_chan !== CW'(1))   begin tests_failed++; $display("FAIL stall_ch1_chan: got %0d want 1", out_chan); end
    tests_run++; if (out_data !== DW'(301)) begin tests_failed++; $display("FAIL stall_ch1_data: got %0d want 301", out_data); end
    tests_run++; if (out_last !== 1'b1)     begin tests_failed++; $display("FAIL stall_ch1_last: got %b want 1", out_last); end
    step();
    tests_run++; if (out_valid !== 1'b0)    begin tests_failed++; $display("FAIL stall_end_valid: got %b want 0", out_valid); end
    tests_run++; if (frame_count !== 16'd3) begin tests_failed++; $display("FAIL stall_fcount: got %0d want 3", frame_count); end
  endtask

  task automatic test_overrun();
    chan_mask = 24'hFFFFFF;
    set_data(400);
    strobe();
    for (int k = 0; k < NF; k++) begin
      tests_run++; if (out_chan !== CW'(k))       begin tests_failed++; $display("FAIL ovr_chan[%0d]: got %0d want %0d", k, out_chan, k); end
      tests_run++; if (out_data !== DW'(400 + k)) begin tests_failed++; $display("FAIL ovr_data[%0d]: got %0d want %0d", k, out_data, 400 + k); end
      if (k == 10) begin
        sample_strobe = 1'b1;
        set_data(500);
      end
      step();
      sample_strobe = 1'b0;
      if (k == 10) begin
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_set: got %b want 1", overrun); end
      end
    end
    tests_run++; if (out_valid !== 1'b0)    begin tests_failed++; $display("FAIL ovr_end_valid: got %b want 0", out_valid); end
    tests_run++; if (overrun !== 1'b1)      begin tests_failed++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    tests_run++; if (frame_count !== 16'd4) begin tests_failed++; $display("FAIL ovr_fcount: got %0d want 4", frame_count); end
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clr: got %b want 0", overrun); end
    // A new overrun in the same cycle as a clear takes priority.
    chan_mask = 24'h000003;
    set_data(600);
    strobe();
    sample_strobe = 1'b1; overrun_clr = 1'b1;
    step();
    sample_strobe = 1'b0; overrun_clr = 1'b0;
    tests_run++; if (overrun !== 1'b1)      begin tests_failed++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
    tests_run++; if (out_chan !== CW'(1))   begin tests_failed++; $display("FAIL ovr_set_wins_chan: got %0d want 1", out_chan); end
    tests_run++; if (out_data !== DW'(601)) begin tests_failed++; $display("FAIL ovr_set_wins_data: got %0d want 601", out_data); end
    step();
    tests_run++; if (frame_count !== 16'd5) begin tests_failed++; $display("FAIL ovr_fcount2: got %0d want 5", frame_count); end
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    chan_mask = 24'h000003;
    set_data(700);
    strobe();
    tests_run++; if (out_data !== DW'(700)) begin tests_failed++; $display("FAIL b2b_f1c0_data: got %0d want 700", out_data); end
    step();
    tests_run++; if (out_last !== 1'b1)     begin tests_failed++; $display("FAIL b2b_f1c1_last: got %b want 1", out_last); end
    set_data(800);
    strobe();
    tests_run++; if (out_valid !== 1'b1)    begin tests_failed++; $display("FAIL b2b_f2c0_valid: got %b want 1", out_valid); end
    tests_run++; if (out_chan !== CW'(0))   begin tests_failed++; $display("FAIL b2b_f2c0_chan: got %0d want 0", out_chan); end
    tests_run++; if (out_data !== DW'(800)) begin tests_failed++; $display("FAIL b2b_f2c0_data: got %0d want 800", out_data); end
    tests_run++; if (overrun !== 1'b0)      begin tests_failed++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    tests_run++; if (frame_count !== 16'd6) begin tests_failed++; $display("FAIL b2b_fcount1: got %0d want 6", frame_count); end
    step();
    tests_run++; if (out_data !== DW'(801)) begin tests_failed++; $display("FAIL b2b_f2c1_data: got %0d want 801", out_data); end
    tests_run++; if (out_last !== 1'b1)     begin tests_failed++; $display("FAIL b2b_f2c1_last: got %b want 1", out_last); end
    step();
    tests_run++; if (out_valid !== 1'b0)    begin tests_failed++; $display("FAIL b2b_end_valid: got %b want 0", out_valid); end
    tests_run++; if (frame_count !== 16'd7) begin tests_failed++; $display("FAIL b2b_fcount2: got %0d want 7", frame_count); end
  endtask

  task automatic test_reset_mid_scan();
    chan_mask = 24'hFFFFFF;
    set_data(900);
    strobe();
    for (int k = 0; k < 5; k++) step();
    tests_run++; if (out_chan !== CW'(5)) begin tests_failed++; $display("FAIL rst_pre_chan: got %0d want 5", out_chan); end
    #2 reset_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0)  begin tests_failed++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    tests_run++; if (busy !== 1'b0)       begin tests_failed++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    tests_run++; if (frame_count !== '0)  begin tests_failed++; $display("FAIL rst_mid_fcount: got %0d want 0", frame_count); end
    tests_run++; if (dbg_state !== 1'b0)  begin tests_failed++; $display("FAIL rst_mid_state: got %b want 0", dbg_state); end
    step();
    reset_n = 1'b1;
    step();
    chan_mask = 24'h000003;
    set_data(1000);
    strobe();
    tests_run++; if (out_chan !== CW'(0))    begin tests_failed++; $display("FAIL rst_post_chan: got %0d want 0", out_chan); end
    tests_run++; if (out_data !== DW'(1000)) begin tests_failed++; $display("FAIL rst_post_data: got %0d want 1000", out_data); end
    step();
    tests_run++; if (out_data !== DW'(1001)) begin tests_failed++; $display("FAIL rst_post_data1: got %0d want 1001", out_data); end
    step();
    tests_run++; if (frame_count !== 16'd1)  begin tests_failed++; $display("FAIL rst_post_fcount: got %0d want 1", frame_count); end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_full_frame();
    test_sparse_mask();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
